prog_loader: RTL and testbench

- Upstream instruction source for the 4-bit accumulator CPU. It replaces the fixed ROM with a writable 16x8 program store.
- A host streams a header byte and the instruction bytes over a valid/ready byte interface.
- Once loading completes, the CPU's pc drives fetch_addr and reads fetch_instr combinationally, exactly as it read the ROM.
- prog_last tells the CPU where its pc must wrap.

---
 rtl/prog_loader_pkg.sv | 14 +
 rtl/prog_ram.sv | 19 +
 rtl/prog_loader.sv | 101 ++++++++++
 tb/tb_prog_loader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared sizes, header magic, NOP word and loader FSM state encodings
package prog_loader_pkg;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam logic [3:0] MAGIC = 4'hA;
  localparam logic [7:0] NOP_INSTR = 8'h00;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] CHK = 3'd3;
  localparam logic [2:0] READY = 3'd4;
  localparam logic [2:0] ERR = 3'd5;
endpackage

// File: rtl/prog_ram.sv
// prog_ram: DEPTH x DW program store, synchronous write, asynchronous read
module prog_ram #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  // write port; contents are deliberately not reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/prog_loader.sv
// prog_loader: host byte stream -> writable program store for the CPU (optional trailing checksum: PROG_LOADER_CHECKSUM_EN)
module prog_loader #(
  parameter int DEPTH = prog_loader_pkg::DEPTH,
  parameter int AW = prog_loader_pkg::AW,
  parameter int DW = prog_loader_pkg::DW,
  parameter logic [3:0] MAGIC = prog_loader_pkg::MAGIC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_req,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] fetch_instr,
  output logic [AW-1:0] prog_last,
  output logic          prog_ready,
  output logic          busy,
  output logic          err
);
  import prog_loader_pkg::*;
  logic [2:0] state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, last_q, last_d;
  logic [DW-1:0] rdata;
  logic acc, hdr_ok, at_last;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  localparam logic [2:0] AFTER_LOAD = CHK;
`else
  localparam logic [2:0] AFTER_LOAD = READY;
`endif
  assign busy = state_q == HDR || state_q == LOAD || state_q == CHK;
  assign prog_ready = state_q == READY;
  assign err = state_q == ERR;
  assign prog_last = last_q;
  assign byte_ready = busy && !load_req;
  assign acc = byte_valid && byte_ready;
  assign hdr_ok = byte_data[7:4] == MAGIC;
  assign at_last = wptr_q == last_q;
  assign fetch_instr = (prog_ready && fetch_addr <= last_q) ? rdata : NOP_INSTR;
  // next-state: load_req restarts from anywhere, otherwise advance on each accepted byte
  always_comb begin
    state_d = state_q;
    wptr_d = wptr_q;
    last_d = last_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d = csum_q;
`endif
    if (load_req) begin
      state_d = HDR;
      wptr_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_d = '0;
`endif
    end else if (acc) begin
      case (state_q)
        HDR: begin
          state_d = hdr_ok ? LOAD : ERR;
          last_d = hdr_ok ? byte_data[AW-1:0] : last_q;
          wptr_d = '0;
        end
        LOAD: begin
          state_d = at_last ? AFTER_LOAD : LOAD;
          wptr_d = at_last ? wptr_q : wptr_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_data;
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK: state_d = (byte_data == csum_q) ? READY : ERR;
`endif
        default: state_d = state_q;
      endcase
    end
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q <= '0;
      last_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      last_q <= last_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  prog_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
    .clk(clk),
    .we(acc && state_q == LOAD),
    .waddr(wptr_q),
    .wdata(byte_data[DW-1:0]),
    .raddr(fetch_addr),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed vector table plus hand sequences for prog_loader
module tb_prog_loader;
  logic clk = 0, rst_n = 1, load_req = 0, byte_valid = 0;
  logic [7:0] byte_data = 0;
  logic [3:0] fetch_addr = 0;
  logic byte_ready, prog_ready, busy, err;
  logic [7:0] fetch_instr;
  logic [3:0] prog_last;
  int n_chk = 0, n_fail = 0, n_acc = 0;

  prog_loader dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .fetch_addr(fetch_addr),
    .fetch_instr(fetch_instr), .prog_last(prog_last), .prog_ready(prog_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (byte_valid && byte_ready) n_acc <= n_acc + 1;

  typedef struct {
    logic lr, v;
    logic [7:0] d;
    logic [3:0] fa;
    logic rdy, pr, er, bz;
    logic [3:0] last;
    logic [7:0] ins;
  } vec_t;
  vec_t vq[$];

  function automatic void add(logic lr, logic v, logic [7:0] d, logic [3:0] fa,
                              logic rdy, logic pr, logic er, logic bz, logic [3:0] last, logic [7:0] ins);
    vec_t t;
    t.lr = lr; t.v = v; t.d = d; t.fa = fa; t.rdy = rdy; t.pr = pr; t.er = er; t.bz = bz; t.last = last; t.ins = ins;
    vq.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lr, input logic v, input logic [7:0] d, input logic [3:0] fa);
    @(negedge clk);
    load_req = lr; byte_valid = v; byte_data = d; fetch_addr = fa;
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int w;
    if (gaps) repeat ($urandom_range(0, 2)) drive(0, 0, 8'h00, 0);
    drive(0, 1, b, 0);
    w = 0;
    while (!byte_ready && w < 20) begin
      drive(0, 1, b, 0);
      w++;
    end
    if (!byte_ready) chk("send timeout", {7'd0, byte_ready}, 8'h01);
  endtask

  initial begin
    logic [7:0] dat [16];
    logic [7:0] x;
    int a0;
    // Table: basic load, bad header, restart mid-load
    add(1,0,8'h00,0, 0,0,0,0,4'd0,8'h00);
    add(0,1,8'hA5,0, 1,0,0,1,4'd0,8'h00);
    add(0,1,8'h11,0, 1,0,0,1,4'd5,8'h00);
    add(0,1,8'h22,0, 1,0,0,1,4'd5,8'h00);
    add(0,1,8'h33,0, 1,0,0,1,4'd5,8'h00);
    add(0,1,8'h44,0, 1,0,0,1,4'd5,8'h00);
    add(0,1,8'h55,0, 1,0,0,1,4'd5,8'h00);
    add(0,1,8'h66,0, 1,0,0,1,4'd5,8'h00);
`ifdef PROG_LOADER_CHECKSUM_EN
    add(0,1,8'h77,0, 1,0,0,1,4'd5,8'h00);
`endif
    add(0,0,8'h00,3, 0,1,0,0,4'd5,8'h44);
    add(0,0,8'h00,6, 0,1,0,0,4'd5,8'h00);
    add(0,1,8'h99,5, 0,1,0,0,4'd5,8'h66);
    add(1,0,8'h00,0, 0,1,0,0,4'd5,8'h11);
    add(0,1,8'h35,0, 1,0,0,1,4'd5,8'h00);
    add(0,1,8'hA2,0, 0,0,1,0,4'd5,8'h00);
    add(1,0,8'h00,0, 0,0,1,0,4'd5,8'h00);
    add(0,1,8'hA3,0, 1,0,0,1,4'd5,8'h00);
    add(0,1,8'h01,0, 1,0,0,1,4'd3,8'h00);
    add(0,1,8'h02,0, 1,0,0,1,4'd3,8'h00);
    add(1,1,8'h03,0, 0,0,0,1,4'd3,8'h00);
    add(0,1,8'hA0,0, 1,0,0,1,4'd3,8'h00);
    add(0,1,8'h7F,0, 1,0,0,1,4'd0,8'h00);
`ifdef PROG_LOADER_CHECKSUM_EN
    add(0,1,8'h7F,0, 1,0,0,1,4'd0,8'h00);
`endif
    add(0,0,8'h00,0, 0,1,0,0,4'd0,8'h7F);
    add(0,0,8'h00,1, 0,1,0,0,4'd0,8'h00);

    // Reset then idle
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 8'h00, i[3:0]);
      chk($sformatf("idle instr[%0d]", i), fetch_instr, 8'h00);
    end
    chk("idle prog_ready", {7'd0, prog_ready}, 8'h00);
    chk("idle byte_ready", {7'd0, byte_ready}, 8'h00);
    chk("idle err", {7'd0, err}, 8'h00);

    foreach (vq[i]) begin
      drive(vq[i].lr, vq[i].v, vq[i].d, vq[i].fa);
      chk($sformatf("v%0d byte_ready", i), {7'd0, byte_ready}, {7'd0, vq[i].rdy});
      chk($sformatf("v%0d prog_ready", i), {7'd0, prog_ready}, {7'd0, vq[i].pr});
      chk($sformatf("v%0d err", i), {7'd0, err}, {7'd0, vq[i].er});
      chk($sformatf("v%0d busy", i), {7'd0, busy}, {7'd0, vq[i].bz});
      chk($sformatf("v%0d prog_last", i), {4'd0, prog_last}, {4'd0, vq[i].last});
      chk($sformatf("v%0d fetch_instr", i), fetch_instr, vq[i].ins);
    end

    // Full 16-word load with random valid gaps
    drive(1, 0, 8'h00, 0);
    a0 = n_acc;
    send(8'hAF, 1);
    x = 8'h00;
    for (int i = 0; i < 16; i++) begin
      dat[i] = {i[3:0], ~i[3:0]};
      x ^= dat[i];
      send(dat[i], 1);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send(x, 1);
    drive(0, 0, 8'h00, 0);
    chk("full accepts", 8'(n_acc - a0), 8'd18);
`else
    drive(0, 0, 8'h00, 0);
    chk("full accepts", 8'(n_acc - a0), 8'd17);
`endif
    chk("full prog_ready", {7'd0, prog_ready}, 8'h01);
    chk("full prog_last", {4'd0, prog_last}, 8'h0F);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 8'h00, i[3:0]);
      chk($sformatf("full instr[%0d]", i), fetch_instr, dat[i]);
    end
    a0 = n_acc;
    drive(0, 1, 8'h99, 0);
    chk("ready extra byte_ready", {7'd0, byte_ready}, 8'h00);
    drive(0, 0, 8'h00, 0);
    chk("ready extra not accepted", 8'(n_acc - a0), 8'd0);
    chk("ready extra instr0", fetch_instr, dat[0]);

    // Asynchronous reset mid-load
    drive(1, 0, 8'h00, 0);
    send(8'hA3, 0);
    send(8'h11, 0);
    @(negedge clk);
    byte_valid = 0;
    rst_n = 0;
    #1;
    chk("rst busy", {7'd0, busy}, 8'h00);
    chk("rst prog_ready", {7'd0, prog_ready}, 8'h00);
    chk("rst byte_ready", {7'd0, byte_ready}, 8'h00);
    chk("rst prog_last", {4'd0, prog_last}, 8'h00);
    chk("rst instr0", fetch_instr, 8'h00);
    @(negedge clk);
    rst_n = 1;

    // Short load, with trailing checksum when enabled
    drive(1, 0, 8'h00, 0);
    send(8'hA1, 0);
    send(8'h0F, 0);
    send(8'hF0, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    drive(0, 0, 8'h00, 0);
    chk("chk wait prog_ready", {7'd0, prog_ready}, 8'h00);
    chk("chk wait busy", {7'd0, busy}, 8'h01);
    send(8'hFF, 0);
`endif
    drive(0, 0, 8'h00, 1);
    chk("short prog_ready", {7'd0, prog_ready}, 8'h01);
    chk("short err", {7'd0, err}, 8'h00);
    chk("short instr1", fetch_instr, 8'hF0);
`ifdef PROG_LOADER_CHECKSUM_EN
    drive(1, 0, 8'h00, 0);
    send(8'hA1, 0);
    send(8'h0F, 0);
    send(8'hF0, 0);
    send(8'hFE, 0);
    drive(0, 0, 8'h00, 1);
    chk("bad csum err", {7'd0, err}, 8'h01);
    chk("bad csum prog_ready", {7'd0, prog_ready}, 8'h00);
    chk("bad csum instr1", fetch_instr, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
